seven_segment_fun1: RTL and testbench
=====================================

// Module: seven_segment_fun1
// PURPOSE
// - Tiny Tapeout user top: four push-buttons drive a one-digit hex counter
//   and a "changing" animation mode on a common-cathode 7-segment display.
// - Every button is synchronised and debounced on chip; each clean press
//   yields one single-cycle event.
// - Sits directly on the TT pin ring.
// - Bidirectional pins are unused and ena is ignored.
// PARAMETERS
// - CLK_HZ           10_000_000  system clock frequency
// - DEBOUNCE_CYCLES  100_000     stable cycles required to accept a level (10 ms)
// - ANIM_CYCLES      1_000_000   cycles per animation step (100 ms)
// PORTS
// - clk      in   1  system clock, all logic on posedge
// - rst_n    in   1  reset, asynchronous, active-low
// - ena      in   1  design-select enable; ignored (tolerates X/Z)
// - ui_in    in   8  [0] inc, [1] dec, [2] mode toggle, [3] clear;
//                    active-high buttons, [7:4] unused
// - uio_in   in   8  unused (tolerates X/Z)
// - uo_out   out  8  [6:0] segments g..a (bit0=a), active-high;
//                    [7] decimal point = mode
// - uio_out  out  8  constant 8'h00
// - uio_oe   out  8  constant 8'h00 (all inputs)
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - all flops cleared: sync chains 0, debounced levels 0, debounce
//     counters 0, value 4'h0, mode 0, anim timer 0, anim position 0.
//   - uo_out = 8'h3F (digit 0, dp off) for as long as rst_n is held low.
//   - Button activity during reset has no effect.
// - Debounce, per button:
//   - 2-FF synchroniser.
//   - If the synchronised level differs from the stable level, the counter
//     increments; otherwise it is cleared to 0.
//   - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the
//     new value and the counter clears.
//   - Pulses or glitches shorter than DEBOUNCE_CYCLES are fully rejected.
//   - A press event is a 1-cycle pulse on a 0->1 transition of the stable
//     level. Release generates no event.
//   - Latency from input edge to event: DEBOUNCE_CYCLES+2 cycles.
// - Value register, 4 bits:
//   - inc event: +1, wrapping F->0.
//   - dec event: -1, wrapping 0->F.
//   - inc and dec in the same cycle: no change.
//   - clear event: value=0, with priority over inc/dec.
// - Mode: a toggle event flips mode.
// - Mode 0 (digit):
//   - uo_out[6:0] = hex decode of value (0..F, standard a-g patterns,
//     b and d lower-case).
//   - Animation timer and position are held at 0.
// - Mode 1 (changing):
//   - A single lit segment rotates a->b->c->d->e->f->a.
//   - The position advances every ANIM_CYCLES cycles and wraps 5->0.
//   - Inc/dec/clear still update value; value is shown again on return
//     to mode 0.
//   - Toggling back to mode 0 resets the position to 0 and the timer to 0.
// - uo_out is combinational from registered state (glitch-free source).
//   uo_out[7] = mode.
// STRUCTURE
// - Package seven_seg_pkg:
//   - SEG_* 7-bit constants for hex glyphs 0..F.
//   - function hex_to_seg(input [3:0]) -> [6:0].
//   - one-hot rotation table ROT[0:5].
//   - button index localparams BTN_INC=0, BTN_DEC=1, BTN_MODE=2, BTN_CLR=3.
// - Sub-module btn_debounce #(DEBOUNCE_CYCLES) (clk, rst_n, btn_in,
//   level, press):
//   - 2-FF synchroniser, counter and edge detector.
//   - Instantiated 4x.
// - Top: value/mode registers, animation timer, output mux, constant tie-offs.
// TESTING (sim with DEBOUNCE_CYCLES=8, ANIM_CYCLES=16)
// 1. Hold rst_n=0 and toggle all buttons
//    -> uo_out stays 8'h3F, uio_out=uio_oe=8'h00.
// 2. Release reset. Press ui_in[0] for 20 cycles, three times
//    -> uo_out 8'h06, 8'h5B, 8'h4F; each change exactly 10 cycles after
//    the press edge.
// 3. On ui_in[1], apply 5-cycle pulses with 5-cycle gaps, repeatedly
//    -> no change.
//    Then a clean press from value 0 -> uo_out=8'h71 (F).
// 4. Value=5. Press ui_in[3] and ui_in[0] together
//    -> uo_out=8'h3F (clear wins).
//    Press ui_in[0] and ui_in[1] together -> unchanged.
// 5. Press ui_in[2] -> uo_out=8'h81, then 8'h82 after 16 cycles,
//    ..., 8'h81 again after 6 steps.
//    Press ui_in[2] again -> digit shown, dp=0.
// 6. Assert rst_n=0 mid-animation -> uo_out=8'h3F immediately
//    (asynchronous), with mode 0 after release.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment button toy.
// - SEG_*      : 7-bit glyphs, bit order g..a (bit0 = segment a), active-high
// - hex_to_seg : nibble -> glyph decode (b and d lower-case)
// - ROT        : one-hot single-segment rotation a->b->c->d->e->f
// - BTN_*      : bit positions of the buttons on ui_in
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [6:0] ROT [0:5] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20};

    localparam int unsigned BTN_INC  = 0;
    localparam int unsigned BTN_DEC  = 1;
    localparam int unsigned BTN_MODE = 2;
    localparam int unsigned BTN_CLR  = 3;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_0;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-FF synchroniser, stability counter, press detector.
// - clk, rst_n : clock / async active-low reset
// - btn_in     : raw asynchronous button level
// - level      : debounced level
// - press      : 1-cycle pulse, coincident with the edge on which level goes 0->1
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q, level_q;
    logic [CW-1:0] cnt_q;
    logic          commit;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign commit = (sync2_q != level_q) && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            if (sync2_q != level_q) begin
                if (commit) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level = level_q;
    // Raised in the cycle before level_q rises so consumers act on that same edge.
    assign press = commit & sync2_q;

endmodule

// File: rtl/seven_segment_fun1.sv
// Tiny Tapeout top: debounced buttons drive a hex digit or a rotating-segment animation.
// - clk, rst_n : clock / async active-low reset
// - ena        : ignored
// - ui_in      : [0] inc, [1] dec, [2] mode toggle, [3] clear (active-high); [7:4] unused
// - uio_in     : unused
// - uo_out     : [6:0] segments g..a, [7] dp = mode
// - uio_out    : tied 8'h00
// - uio_oe     : tied 8'h00 (all inputs)
module seven_segment_fun1
    import seven_seg_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 100_000,
    parameter int unsigned ANIM_CYCLES     = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned TW = (ANIM_CYCLES > 2) ? $clog2(ANIM_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(ANIM_CYCLES - 1);
    localparam logic [2:0]    POS_LAST  = 3'd5;

    logic [3:0]    press;
    logic [3:0]    level;
    logic [3:0]    value_q;
    logic          mode_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    pos_q;
    logic [6:0]    seg;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_in(ui_in[i]),
            .level (level[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 4'h0;
            mode_q  <= 1'b0;
            timer_q <= '0;
            pos_q   <= '0;
        end else begin
            if (press[BTN_CLR]) begin
                value_q <= 4'h0;
            end else if (press[BTN_INC] && !press[BTN_DEC]) begin
                value_q <= value_q + 4'h1;
            end else if (press[BTN_DEC] && !press[BTN_INC]) begin
                value_q <= value_q - 4'h1;
            end

            if (press[BTN_MODE]) begin
                mode_q <= ~mode_q;
            end

            // Any mode change restarts the animation from segment a.
            if (!mode_q || press[BTN_MODE]) begin
                timer_q <= '0;
                pos_q   <= '0;
            end else if (timer_q == TIMER_MAX) begin
                timer_q <= '0;
                pos_q   <= (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    always_comb begin
        seg = hex_to_seg(value_q);
        if (mode_q) begin
            case (pos_q)
                3'd0:    seg = ROT[0];
                3'd1:    seg = ROT[1];
                3'd2:    seg = ROT[2];
                3'd3:    seg = ROT[3];
                3'd4:    seg = ROT[4];
                3'd5:    seg = ROT[5];
                default: seg = ROT[0];
            endcase
        end
        uo_out = {mode_q, seg};
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Inputs with no function are gathered here so they are visibly consumed.
    logic unused_ok;
    assign unused_ok = ^{ena, uio_in, ui_in[7:4], level, CLK_HZ[0]};

endmodule

// File: tb/tb_seven_segment_fun1.sv
module tb_seven_segment_fun1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seven_segment_fun1 #(
        .CLK_HZ         (10_000_000),
        .DEBOUNCE_CYCLES(8),
        .ANIM_CYCLES    (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: held 20 cycles, released for 20 cycles.
    task automatic press(input logic [3:0] m);
        ui_in = {4'h0, m};
        step(20);
        ui_in = 8'h00;
        step(20);
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        ena    = 1'bx;
        uio_in = 8'hzz;
        ui_in  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ui_in = {4'h0, 4'(i * 5)};
            step(3);
            @(negedge clk);
            total++;
            if (uo_out !== 8'h3F) begin
                bad++;
                $display("FAIL reset_uo[%0d]: got %h want 3f", i, uo_out);
            end
        end
        total++;
        if (uio_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_uio_out: got %h want 00", uio_out);
        end
        total++;
        if (uio_oe !== 8'h00) begin
            bad++;
            $display("FAIL reset_uio_oe: got %h want 00", uio_oe);
        end
        ui_in = 8'h00;
        step(2);
        rst_n = 1'b1;
        step(20);
        total++;
        if (uo_out !== 8'h3F) begin
            bad++;
            $display("FAIL after_reset_uo: got %h want 3f", uo_out);
        end
    endtask

    task automatic test_inc_latency;
        logic [7:0] exp_seg [0:2];
        logic [7:0] prev;
        exp_seg = '{8'h06, 8'h5B, 8'h4F};
        prev    = 8'h3F;
        for (int k = 0; k < 3; k++) begin
            ui_in = 8'h01;
            repeat (9) @(posedge clk);
            @(negedge clk);
            total++;
            if (uo_out !== prev) begin
                bad++;
                $display("FAIL inc%0d_edge9: got %h want %h", k, uo_out, prev);
            end
            @(posedge clk);
            @(negedge clk);
            total++;
            if (uo_out !== exp_seg[k]) begin
                bad++;
                $display("FAIL inc%0d_edge10: got %h want %h", k, uo_out, exp_seg[k]);
            end
            step(10);
            ui_in = 8'h00;
            step(20);
            total++;
            if (uo_out !== exp_seg[k]) begin
                bad++;
                $display("FAIL inc%0d_release: got %h want %h", k, uo_out, exp_seg[k]);
            end
            prev = exp_seg[k];
        end
    endtask

    task automatic test_glitch_and_wrap;
        for (int r = 0; r < 6; r++) begin
            ui_in = 8'h02;
            step(5);
            ui_in = 8'h00;
            step(5);
        end
        step(10);
        total++;
        if (uo_out !== 8'h4F) begin
            bad++;
            $display("FAIL glitch_reject: got %h want 4f", uo_out);
        end
        press(4'h8);
        total++;
        if (uo_out !== 8'h3F) begin
            bad++;
            $display("FAIL clear: got %h want 3f", uo_out);
        end
        press(4'h2);
        total++;
        if (uo_out !== 8'h71) begin
            bad++;
            $display("FAIL dec_wrap_0_to_f: got %h want 71", uo_out);
        end
        press(4'h1);
        total++;
        if (uo_out !== 8'h3F) begin
            bad++;
            $display("FAIL inc_wrap_f_to_0: got %h want 3f", uo_out);
        end
    endtask

    task automatic test_combos;
        for (int i = 0; i < 5; i++) press(4'h1);
        total++;
        if (uo_out !== 8'h6D) begin
            bad++;
            $display("FAIL value5: got %h want 6d", uo_out);
        end
        press(4'h9);
        total++;
        if (uo_out !== 8'h3F) begin
            bad++;
            $display("FAIL clear_beats_inc: got %h want 3f", uo_out);
        end
        press(4'h1);
        press(4'h1);
        press(4'h3);
        total++;
        if (uo_out !== 8'h5B) begin
            bad++;
            $display("FAIL inc_dec_cancel: got %h want 5b", uo_out);
        end
    endtask

    task automatic test_mode_anim;
        logic [7:0] rot [0:5];
        logic [7:0] prev;
        rot = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0};
        ui_in = 8'h04;
        repeat (9) @(posedge clk);
        @(negedge clk);
        total++;
        if (uo_out !== 8'h5B) begin
            bad++;
            $display("FAIL mode_edge9: got %h want 5b", uo_out);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (uo_out !== 8'h81) begin
            bad++;
            $display("FAIL mode_enter: got %h want 81", uo_out);
        end
        ui_in = 8'h00;
        prev  = 8'h81;
        for (int s = 1; s <= 6; s++) begin
            repeat (15) @(posedge clk);
            @(negedge clk);
            total++;
            if (uo_out !== prev) begin
                bad++;
                $display("FAIL anim_hold%0d: got %h want %h", s, uo_out, prev);
            end
            @(posedge clk);
            @(negedge clk);
            total++;
            if (uo_out !== rot[s % 6]) begin
                bad++;
                $display("FAIL anim_step%0d: got %h want %h", s, uo_out, rot[s % 6]);
            end
            prev = rot[s % 6];
        end
        press(4'h4);
        total++;
        if (uo_out !== 8'h5B) begin
            bad++;
            $display("FAIL mode_exit: got %h want 5b", uo_out);
        end
    endtask

    task automatic test_async_reset;
        press(4'h4);
        total++;
        if (uo_out[7] !== 1'b1) begin
            bad++;
            $display("FAIL anim_dp_before_reset: got %b want 1", uo_out[7]);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (uo_out !== 8'h3F) begin
            bad++;
            $display("FAIL async_reset: got %h want 3f", uo_out);
        end
        step(3);
        rst_n = 1'b1;
        step(20);
        total++;
        if (uo_out !== 8'h3F) begin
            bad++;
            $display("FAIL post_reset_mode0: got %h want 3f", uo_out);
        end
        press(4'h1);
        total++;
        if (uo_out !== 8'h06) begin
            bad++;
            $display("FAIL post_reset_inc: got %h want 06", uo_out);
        end
    endtask

    initial begin
        test_reset();
        test_inc_latency();
        test_glitch_and_wrap();
        test_combos();
        test_mode_anim();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
